// File: rtl/cpmath_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, funct codes,
// ALU operations and FSM states, plus the instruction legality/ALU decode helpers.
package cpmath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluOp_e;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  // An R-type with an unsupported funct is as illegal as an unknown opcode.
  function automatic logic legalOp(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (opcode)
      OP_RTYPE:                            ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic aluOp_e functAluOp(input logic [5:0] funct);
    aluOp_e op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpmath_if.sv
// Shared instruction/data memory port: req/ready handshake, held request,
// read data sampled in the ready cycle.
interface cpmath_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cpmath_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one synchronous
// write port; register 0 is never written so it always reads zero.
module cpmath_regfile
  import cpmath_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  raddrA,
  input  logic [IDX_W-1:0]  raddrB,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB
);

  logic [DATA_W-1:0] regs [NREGS];

  // NOTE: the array has a reset so every register starts at zero; that forces
  // flops rather than a RAM macro, which is acceptable at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdataA = regs[raddrA];
  assign rdataB = regs[raddrB];

endmodule

// File: rtl/cpmath_mc_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB control driving one
// shared instruction/data memory port that tolerates any number of wait states.
module cpmath_mc_core
  import cpmath_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  cpmath_if.master          memBus,
  output logic              halt,
  output logic [DATA_W-1:0] pc_dbg,
  output logic              retire
);

  localparam int IDX_W = $clog2(NREGS);

  state_e            state, nextState;
  logic [DATA_W-1:0] pc, regA, regB, aluOut, mdr;
  logic [31:0]       ir;
  logic              memReq, retireNext, accessDone;
  logic [DATA_W-1:0] sextImm, srcB, aluResult, rfA, rfB, rfWdata;
  logic [IDX_W-1:0]  rfWaddr;
  logic [5:0]        opcode, funct;
  aluOp_e            aluOp;
  logic              unusedShamt;

  assign opcode      = ir[31:26];
  assign funct       = ir[5:0];
  assign unusedShamt = ^ir[10:6];
  assign sextImm     = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign accessDone  = memReq && memBus.mem_ready;

  assign rfWaddr = (opcode == OP_RTYPE) ? ir[11 +: IDX_W] : ir[16 +: IDX_W];
  assign rfWdata = (opcode == OP_LW) ? mdr : aluOut;

  cpmath_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) uRegfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddrA (ir[21 +: IDX_W]),
    .raddrB (ir[16 +: IDX_W]),
    .we     (state == S_WB),
    .waddr  (rfWaddr),
    .wdata  (rfWdata),
    .rdataA (rfA),
    .rdataB (rfB)
  );

  always_comb begin
    aluOp = (opcode == OP_RTYPE) ? functAluOp(funct) : ALU_ADD;
    srcB  = (opcode == OP_RTYPE) ? regB : sextImm;
    aluResult = regA + srcB;
    case (aluOp)
      ALU_SUB: aluResult = regA - srcB;
      ALU_AND: aluResult = regA & srcB;
      ALU_OR:  aluResult = regA | srcB;
      ALU_SLT: aluResult = DATA_W'($signed(regA) < $signed(srcB));
      default: aluResult = regA + srcB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    nextState  = state;
    retireNext = 1'b0;
    case (state)
      S_FETCH:  if (accessDone) nextState = S_DECODE;
      S_DECODE: nextState = legalOp(opcode, funct) ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (opcode)
          OP_BEQ, OP_J: begin
            nextState  = S_FETCH;
            retireNext = 1'b1;
          end
          OP_LW, OP_SW: nextState = (aluResult[1:0] != 2'b00) ? S_HALT : S_MEM;
          default:      nextState = S_WB;
        endcase
      end
      S_MEM: begin
        if (accessDone) begin
          nextState  = (opcode == OP_SW) ? S_FETCH : S_WB;
          retireNext = (opcode == OP_SW);
        end
      end
      S_WB: begin
        nextState  = S_FETCH;
        retireNext = 1'b1;
      end
      default: nextState = S_HALT;
    endcase
  end

  // The request is a flop, so it follows the state the FSM is about to enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= '0;
      regA   <= '0;
      regB   <= '0;
      aluOut <= '0;
      mdr    <= '0;
      memReq <= 1'b0;
      retire <= 1'b0;
    end else begin
      memReq <= (nextState == S_FETCH) || (nextState == S_MEM);
      retire <= retireNext;
      case (state)
        S_FETCH: begin
          if (accessDone) begin
            ir <= memBus.mem_rdata[31:0];
            pc <= pc + DATA_W'(4);
          end
        end
        S_DECODE: begin
          regA   <= rfA;
          regB   <= rfB;
          aluOut <= pc + (sextImm << 2);
        end
        S_EXEC: begin
          aluOut <= aluResult;
          if (opcode == OP_BEQ && regA == regB) pc <= aluOut;
          if (opcode == OP_J) pc <= {pc[DATA_W-1:28], ir[25:0], 2'b00};
        end
        S_MEM: if (accessDone && opcode == OP_LW) mdr <= memBus.mem_rdata;
        default: ;
      endcase
    end
  end

  assign memBus.mem_req   = memReq;
  assign memBus.mem_we    = memReq && (state == S_MEM) && (opcode == OP_SW);
  assign memBus.mem_addr  = (state == S_MEM) ? aluOut : pc;
  assign memBus.mem_wdata = regB;
  assign halt             = (state == S_HALT);
  assign pc_dbg           = pc;

endmodule

// File: tb/tb_cpmath_mc_core.sv
// Self-checking bench for cpmath_mc_core: directed programs plus randomized
// straight-line programs checked against an instruction-level reference model.
module tb_cpmath_mc_core;

  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] FILL     = 32'hDEAD_BEEF;
  localparam logic [31:0] HALT_OP  = 32'hFC00_0000;
  localparam logic [5:0]  T_J = 6'h02, T_BEQ = 6'h04, T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B;
  localparam int          NRAND    = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt, retire;
  logic [31:0] pc_dbg;

  cpmath_if #(.DATA_W(DATA_W)) bus ();

  cpmath_mc_core #(.DATA_W(DATA_W), .NREGS(32), .RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .memBus (bus),
    .halt   (halt),
    .pc_dbg (pc_dbg),
    .retire (retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic [31:0] mem [0:1023];
  acc_t        accLog[$];
  int          retireCyc[$];
  int          cycle = 0;
  int          firstReq = -1;
  int          waitCycles = 0;
  int          waitCnt = 0;
  bit          idleNoise = 1'b0;
  int          total = 0;
  int          bad = 0;

  // Memory responder: ready after waitCycles idle request cycles, random
  // ready/data while no request is pending.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      waitCnt = 0;
      bus.mem_ready = 1'b0;
    end else begin
      if (retire) retireCyc.push_back(cycle);
      if (bus.mem_req) begin
        if (firstReq < 0) firstReq = cycle;
        if (waitCnt >= waitCycles) begin
          bus.mem_ready = 1'b1;
          waitCnt = 0;
          if (bus.mem_we) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
          else            bus.mem_rdata = mem[bus.mem_addr[11:2]];
          accLog.push_back('{bus.mem_we, bus.mem_addr,
                             bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr[11:2]]});
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          waitCnt++;
        end
      end else begin
        bus.mem_ready = idleNoise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
        waitCnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] jType(input logic [25:0] target);
    return {T_J, target};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 1024; i++) mem[i] = FILL;
  endtask

  task automatic startRun(input int waitN, input bit noise);
    rst_n = 1'b0;
    waitCycles = waitN;
    idleNoise = noise;
    repeat (2) @(negedge clk);
    accLog.delete();
    retireCyc.delete();
    firstReq = -1;
    rst_n = 1'b1;
  endtask

  task automatic runUntilHalt(input int budget);
    int n;
    n = 0;
    while (halt !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("halt reached", 32'(halt), 32'h1);
  endtask

  function automatic logic [31:0] fetchAfter(input logic [31:0] a);
    for (int i = 0; i + 1 < accLog.size(); i++)
      if (!accLog[i].we && accLog[i].addr == a) return accLog[i + 1].addr;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] storeDataAt(input logic [31:0] a);
    for (int i = 0; i < accLog.size(); i++)
      if (accLog[i].we && accLog[i].addr == a) return accLog[i].data;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int retireOff(input int i);
    return (i < retireCyc.size()) ? retireCyc[i] - firstReq : -1;
  endfunction

  function automatic int retireGap(input int i);
    return (i + 1 < retireCyc.size()) ? retireCyc[i + 1] - retireCyc[i] : -1;
  endfunction

  initial begin
    logic [31:0] rm [8];
    logic [31:0] dm [4];
    logic [31:0] instr, res, pcw;
    logic [4:0]  rs, rt, rdI;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          kind, k, n, reqSeen;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req", 32'(bus.mem_req), 32'h0);
    check("reset mem_we", 32'(bus.mem_we), 32'h0);
    check("reset halt", 32'(halt), 32'h0);
    check("reset retire", 32'(retire), 32'h0);
    check("reset pc", pc_dbg, RESET_PC);

    // addi/addi/add with zero wait states; R3 stored to 0x80 for observation
    clearMem();
    put(32'h00, iType(T_ADDI, 5'd0, 5'd1, 16'd5));
    put(32'h04, iType(T_ADDI, 5'd0, 5'd2, 16'd7));
    put(32'h08, rType(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, iType(T_SW, 5'd0, 5'd3, 16'h0080));
    put(32'h10, HALT_OP);
    startRun(0, 1'b1);
    #1 check("req low in first cycle", 32'(bus.mem_req), 32'h0);
    @(negedge clk);
    #1 check("req high in second cycle", 32'(bus.mem_req), 32'h1);
    runUntilHalt(300);
    check("first fetch addr", accLog.size() > 0 ? accLog[0].addr : 32'hFFFF_FFFF, RESET_PC);
    check("retire #1 offset", 32'(retireOff(0)), 32'd4);
    check("retire #2 offset", 32'(retireOff(1)), 32'd8);
    check("retire #3 offset", 32'(retireOff(2)), 32'd12);
    check("R3 = 5+7", mem[32'h80 >> 2], 32'd12);
    check("halt pc after sw", pc_dbg, 32'h14);

    // sw/lw with 3 wait states per access; program lives at 0x100
    clearMem();
    put(32'h000, jType(26'h40));
    put(32'h100, iType(T_ADDI, 5'd0, 5'd3, 16'd12));
    put(32'h104, iType(T_SW, 5'd0, 5'd3, 16'd8));
    put(32'h108, iType(T_LW, 5'd0, 5'd4, 16'd8));
    put(32'h10C, iType(T_SW, 5'd0, 5'd4, 16'h0084));
    put(32'h110, HALT_OP);
    startRun(3, 1'b1);
    runUntilHalt(500);
    check("store to 8 data", storeDataAt(32'h8), 32'd12);
    check("R4 loaded", mem[32'h84 >> 2], 32'd12);
    check("sw cycles with waits", 32'(retireGap(1)), 32'd10);
    check("lw cycles with waits", 32'(retireGap(2)), 32'd11);
    check("halt pc 0x114", pc_dbg, 32'h114);

    // beq taken/not taken, j, write to R0
    clearMem();
    put(32'h00, iType(T_ADDI, 5'd0, 5'd1, 16'd3));
    put(32'h04, iType(T_ADDI, 5'd0, 5'd2, 16'd4));
    put(32'h08, iType(T_ADDI, 5'd0, 5'd6, 16'd1));
    put(32'h0C, iType(T_ADDI, 5'd0, 5'd7, 16'd2));
    put(32'h10, iType(T_BEQ, 5'd1, 5'd1, 16'd2));
    put(32'h14, HALT_OP);
    put(32'h18, HALT_OP);
    put(32'h1C, iType(T_BEQ, 5'd1, 5'd2, 16'd5));
    put(32'h20, jType(26'h40));
    put(32'h100, rType(5'd1, 5'd2, 5'd0, 6'h20));
    put(32'h104, iType(T_SW, 5'd0, 5'd0, 16'h0088));
    put(32'h108, HALT_OP);
    startRun(0, 1'b1);
    runUntilHalt(300);
    check("beq taken target", fetchAfter(32'h10), 32'h1C);
    check("beq not taken", fetchAfter(32'h1C), 32'h20);
    check("j target", fetchAfter(32'h20), 32'h100);
    check("R0 stays zero", mem[32'h88 >> 2], 32'h0);
    check("beq cycles", 32'(retireGap(3)), 32'd3);
    check("j cycles", 32'(retireGap(5)), 32'd3);
    check("retire count", 32'(retireCyc.size()), 32'd9);
    check("halt pc 0x10C", pc_dbg, 32'h10C);

    // Illegal opcode: halt and no further requests
    clearMem();
    put(32'h00, HALT_OP);
    startRun(0, 1'b1);
    runUntilHalt(100);
    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req) reqSeen++;
    end
    #1;
    check("no req while halted", 32'(reqSeen), 32'h0);
    check("halt still set", 32'(halt), 32'h1);
    check("illegal op pc", pc_dbg, 32'h4);
    check("no retire on illegal", 32'(retireCyc.size()), 32'h0);

    // Unsupported funct under opcode 0
    clearMem();
    put(32'h00, rType(5'd1, 5'd2, 5'd3, 6'h21));
    startRun(0, 1'b1);
    runUntilHalt(100);
    check("bad funct pc", pc_dbg, 32'h4);

    // Misaligned load
    clearMem();
    put(32'h00, iType(T_LW, 5'd0, 5'd2, 16'd6));
    startRun(0, 1'b1);
    runUntilHalt(100);
    check("misaligned lw pc", pc_dbg, 32'h4);
    check("misaligned lw no access", 32'(accLog.size()), 32'h1);

    // Reset while a fetch is waiting on ready
    clearMem();
    put(32'h000, jType(26'h40));
    put(32'h100, HALT_OP);
    startRun(50, 1'b0);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 32'h100) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached pending fetch", 32'(bus.mem_req), 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("req drops in reset", 32'(bus.mem_req), 32'h0);
    check("we low in reset", 32'(bus.mem_we), 32'h0);
    check("retire low in reset", 32'(retire), 32'h0);
    check("pc reset mid-access", pc_dbg, RESET_PC);
    waitCycles = 0;
    @(negedge clk);
    accLog.delete();
    retireCyc.delete();
    firstReq = -1;
    rst_n = 1'b1;
    runUntilHalt(200);
    check("fetch restarts at RESET_PC", accLog.size() > 0 ? accLog[0].addr : 32'hFFFF_FFFF, RESET_PC);
    check("pc after restart", pc_dbg, 32'h104);

    // Random straight-line programs against an instruction-level model
    for (int round = 0; round < 2; round++) begin
      clearMem();
      for (int r = 0; r < 8; r++) rm[r] = 32'h0;
      for (int j = 0; j < 4; j++) dm[j] = FILL;
      pcw = 32'h0;
      for (int i = 0; i < NRAND; i++) begin
        kind = (i < 4) ? 0 : $urandom_range(0, 9);
        rs   = 5'($urandom_range(0, 7));
        rt   = 5'($urandom_range(1, 7));
        rdI  = 5'($urandom_range(0, 7));
        k    = $urandom_range(0, 3);
        imm  = 16'($urandom);
        if (kind <= 1) begin
          instr = iType(T_ADDI, rs, rt, imm);
          rm[rt[2:0]] = rm[rs[2:0]] + {{16{imm[15]}}, imm};
        end else if (kind <= 6) begin
          case ($urandom_range(0, 4))
            0:       begin fn = 6'h20; res = rm[rs[2:0]] + rm[rdI[2:0]]; end
            1:       begin fn = 6'h22; res = rm[rs[2:0]] - rm[rdI[2:0]]; end
            2:       begin fn = 6'h24; res = rm[rs[2:0]] & rm[rdI[2:0]]; end
            3:       begin fn = 6'h25; res = rm[rs[2:0]] | rm[rdI[2:0]]; end
            default: begin
              fn  = 6'h2A;
              res = ($signed(rm[rs[2:0]]) < $signed(rm[rdI[2:0]])) ? 32'd1 : 32'd0;
            end
          endcase
          // rdI doubles as the second source; the destination is drawn fresh
          rt = 5'($urandom_range(0, 7));
          instr = rType(rs, rdI, rt, fn);
          if (rt != 5'd0) rm[rt[2:0]] = res;
        end else if (kind == 7) begin
          instr = iType(T_SW, 5'd0, rs, 16'(32'h300 + 4 * k));
          dm[k] = rm[rs[2:0]];
        end else begin
          instr = iType(T_LW, 5'd0, rt, 16'(32'h300 + 4 * k));
          rm[rt[2:0]] = dm[k];
        end
        put(pcw, instr);
        pcw = pcw + 32'd4;
      end
      for (int r = 1; r < 8; r++) begin
        put(pcw, iType(T_SW, 5'd0, 5'(r), 16'(32'h200 + 4 * r)));
        pcw = pcw + 32'd4;
      end
      put(pcw, HALT_OP);
      startRun($urandom_range(0, 2), 1'b1);
      runUntilHalt(3000);
      for (int r = 1; r < 8; r++)
        check($sformatf("rand%0d R%0d", round, r), mem[(32'h200 >> 2) + r], rm[r]);
      for (int j = 0; j < 4; j++)
        check($sformatf("rand%0d data%0d", round, j), mem[(32'h300 >> 2) + j], dm[j]);
      check($sformatf("rand%0d retires", round), 32'(retireCyc.size()), 32'(NRAND + 7));
      check($sformatf("rand%0d halt pc", round), pc_dbg, pcw + 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
